// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: sequential increment, load of an aligned target,
// and a one-cycle flag when a redirect target was not word-aligned.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_load,
  input  logic [31:0] i_load_addr,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_redirect_target,
  output logic        o_misalign_err
);

  logic [31:0] r_pc;
  logic        r_misalign_err;

  assign o_redirect_target = align_word(i_redirect_pc);
  assign o_pc              = r_pc;
  assign o_misalign_err    = r_misalign_err;

  // PC update: a load (redirect or drained pending target) beats increment; add wraps mod 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= align_word(i_load_addr);
    end else if (i_inc) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  // Misalignment pulse, raised the cycle after any redirect with nonzero low bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= i_redirect_valid & (|i_redirect_pc[1:0]);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC sequencing, req/ack instruction-memory reads and the
// instruction register feeding the decoder. Redirects discard stale fetches.
//
// state | meaning
// FETCH | request outstanding at pc (held off for one cycle after reset)
// HOLD  | instruction register valid, waiting for the decoder to consume it
// DRAIN | redirect arrived mid-request; wait for the ack, drop its data
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  // r_started gates the request off for the first cycle out of reset, so an
  // ack belonging to a request abandoned by reset can never be captured.
  logic        r_started;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [31:0] r_pending_pc;

  logic [31:0] w_pc;
  logic [31:0] w_target;
  logic [31:0] w_load_addr;
  logic        w_capture;
  logic        w_inc;
  logic        w_load;
  logic        w_load_pend;
  logic        w_pend_we;
  logic        w_clr_valid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_inc             (w_inc),
    .i_load            (w_load),
    .i_load_addr       (w_load_addr),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_pc     (redirect_pc),
    .o_pc              (w_pc),
    .o_redirect_target (w_target),
    .o_misalign_err    (misalign_err)
  );

  assign w_load_addr = w_load_pend ? r_pending_pc : w_target;

  assign mem_req     = r_started & ((r_state == FETCH) | (r_state == DRAIN));
  assign mem_addr    = w_pc;
  assign Instruction = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Next-state and datapath strobes; redirect outranks ack, stall and consume
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_inc       = 1'b0;
    w_load      = 1'b0;
    w_load_pend = 1'b0;
    w_pend_we   = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      FETCH: begin
        if (!r_started) begin
          w_load = redirect_valid;
        end else if (redirect_valid) begin
          if (mem_ack) begin
            w_load = 1'b1;
          end else begin
            w_pend_we   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end else if (mem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_load      = 1'b1;
          w_clr_valid = 1'b1;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_inc       = 1'b1;
          w_clr_valid = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          if (mem_ack) begin
            w_load      = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_pend_we = 1'b1;
          end
        end else if (mem_ack) begin
          w_load      = 1'b1;
          w_load_pend = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Instruction register; contents persist after consume, only valid drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr       <= mem_rdata;
      r_instr_pc    <= w_pc;
      r_instr_valid <= 1'b1;
    end else if (w_clr_valid) begin
      r_instr_valid <= 1'b0;
    end
  end

  // Redirect target remembered while the stale request drains; last one wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending_pc <= RESET_PC;
    end else if (w_pend_we) begin
      r_pending_pc <= w_target;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable
// memory model and a scoreboard of instructions expected at the decoder.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        misalign_err;

  logic        m_ack;
  logic [31:0] m_rd;
  logic        spur_ack;
  int          lat;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem_tbl [logic [31:0]];

  assign mem_ack   = m_ack | spur_ack;
  assign mem_rdata = spur_ack ? 32'hBAD0_BAD0 : m_rd;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .Instruction    (Instruction),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.ins = mem_data(a);
    e.pc  = a;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (instr_valid !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk1("wait_valid", instr_valid, 1'b1);
  endtask

  task automatic wait_ack(input logic [31:0] a, input int max);
    int k;
    k = 0;
    while (mem_ack !== 1'b1 && k < max) begin
      chk1("drain_req", mem_req, 1'b1);
      chk("drain_addr", mem_addr, a);
      @(negedge clk);
      k++;
    end
    chk1("drain_ack_seen", mem_ack, 1'b1);
    chk("drain_addr_at_ack", mem_addr, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk1({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, Instruction, 32'h0);
    chk({tag, "_ipc"}, instr_pc, 32'h0);
    chk1({tag, "_misalign"}, misalign_err, 1'b0);
  endtask

  // Memory model: answers a request after lat idle cycles (lat=0 acks same cycle)
  initial begin
    int cnt;
    cnt   = 0;
    m_ack = 1'b0;
    m_rd  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (cnt >= lat) begin
          m_ack = 1'b1;
          m_rd  = mem_data(mem_addr);
          cnt   = 0;
        end else begin
          m_ack = 1'b0;
          cnt++;
        end
      end else begin
        m_ack = 1'b0;
        cnt   = 0;
      end
    end
  end

  // Decoder-side monitor: each new valid instruction must match the scoreboard head
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
        chk1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_instr", Instruction, e.ins);
          chk("sb_pc", instr_pc, e.pc);
        end
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    spur_ack       = 1'b0;
    lat            = 0;
    mem_tbl[32'h0]  = 32'h1111_1111;
    mem_tbl[32'h4]  = 32'h2222_2222;
    mem_tbl[32'h10] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    push_exp(32'hC);
    push_exp(32'h10);
    rst_n = 1'b1;

    // zero-wait sequential fetch, one instruction per two cycles
    @(negedge clk);
    chk1("seq0_req", mem_req, 1'b1);
    chk("seq0_addr", mem_addr, 32'h0);
    @(negedge clk);
    chk1("seq0_valid", instr_valid, 1'b1);
    chk1("seq0_hold_req", mem_req, 1'b0);
    chk("seq0_instr", Instruction, 32'h1111_1111);
    @(negedge clk);
    chk1("seq1_req", mem_req, 1'b1);
    chk("seq1_addr", mem_addr, 32'h4);
    chk1("seq1_valid", instr_valid, 1'b0);
    @(negedge clk);
    chk1("seq1_valid_hold", instr_valid, 1'b1);
    chk("seq1_instr", Instruction, 32'h2222_2222);
    @(negedge clk);
    chk1("seq2_req", mem_req, 1'b1);
    chk("seq2_addr", mem_addr, 32'h8);

    // stall holds the instruction at 0x10
    repeat (4) @(negedge clk);
    chk("stall_fetch_addr", mem_addr, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", Instruction, 32'hDEAD_BEEF);
      chk("stall_ipc", instr_pc, 32'h10);
      chk1("stall_req", mem_req, 1'b0);
    end
    push_exp(32'h14);
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    chk1("after_stall_req", mem_req, 1'b1);
    chk("after_stall_addr", mem_addr, 32'h14);
    wait_valid(20);

    // redirect from HOLD to 0x20, then redirect to 0x100 mid-request
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk1("hold_redir_valid", instr_valid, 1'b0);
    chk1("hold_redir_req", mem_req, 1'b1);
    chk("hold_redir_addr", mem_addr, 32'h20);
    chk1("hold_redir_misalign", misalign_err, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    push_exp(32'h100);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_ack(32'h20, 10);
    @(negedge clk);
    chk1("drain_done_req", mem_req, 1'b1);
    chk("drain_done_addr", mem_addr, 32'h100);
    wait_valid(20);

    // two redirects while draining: last target wins
    @(negedge clk);
    chk("seq_104_addr", mem_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_pc    = 32'h300;
    push_exp(32'h300);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_ack(32'h104, 10);
    @(negedge clk);
    chk("last_redir_addr", mem_addr, 32'h300);
    wait_valid(20);

    // misaligned redirect in HOLD
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    push_exp(32'h100);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk1("misalign_pulse", misalign_err, 1'b1);
    chk1("misalign_drop", instr_valid, 1'b0);
    chk1("misalign_req", mem_req, 1'b1);
    chk("misalign_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk1("misalign_once", misalign_err, 1'b0);
    wait_valid(20);

    // redirect coinciding with a zero-wait ack in FETCH, then wrap at top of memory
    lat = 0;
    push_exp(32'hFFFF_FFFC);
    @(negedge clk);
    chk("ackredir_addr", mem_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk1("ackredir_valid", instr_valid, 1'b0);
    chk1("ackredir_req", mem_req, 1'b1);
    chk("ackredir_target", mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk1("top_valid", instr_valid, 1'b1);
    chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
    lat = 3;
    @(negedge clk);
    chk1("wrap_req", mem_req, 1'b1);
    chk("wrap_addr", mem_addr, 32'h0);

    // reset with a request outstanding, then a stray ack right after release
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    push_exp(32'h0);
    rst_n    = 1'b1;
    spur_ack = 1'b1;
    lat      = 0;
    @(negedge clk);
    spur_ack = 1'b0;
    chk1("restart_req", mem_req, 1'b1);
    chk("restart_addr", mem_addr, 32'h0);
    chk1("restart_valid", instr_valid, 1'b0);
    chk("restart_instr", Instruction, 32'h0);
    wait_valid(10);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of the instruction decoder. Maintains the program counter and issues word reads to instruction memory over a req/ack handshake. Holds each returned 32-bit word in an instruction register that drives the decoder's `Instruction` input. Honours downstream stall and branch/jump redirects, discarding any fetch made stale by a redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `PC_INC`, 4: byte increment between sequential fetches.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word-aligned fetch address; stable while `mem_req`=1.
- `mem_ack`  in  1  single-cycle response strobe; `mem_rdata` valid in that cycle.
- `mem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  downstream cannot accept the held instruction this cycle.
- `redirect_valid`  in  1  single-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target address.
- `Instruction`  out  32  held instruction word, to the decoder.
- `instr_valid`  out  1  `Instruction` is valid.
- `instr_pc`  out  32  address `Instruction` was fetched from.
- `misalign_err`  out  1  one-cycle pulse: `redirect_pc[1:0]` was nonzero.

## Operation
- FSM states are FETCH, HOLD and DRAIN.
- **FETCH**
  - Drive `mem_req`=1, `mem_addr`=pc.
  - On `mem_ack`: capture `mem_rdata` into `Instruction`, pc into `instr_pc`, set `instr_valid`, go to HOLD.
- **HOLD**
  - `instr_valid`=1 and `mem_req`=0.
  - When `stall`=0 at an edge, the instruction is consumed: pc += `PC_INC` (mod 2^32 wrap), clear `instr_valid`, go to FETCH.
  - When `stall`=1, all outputs remain unchanged.
- **DRAIN**
  - A redirect arrived while a request was outstanding.
  - Keep `mem_req`=1 with the old `mem_addr` until `mem_ack`, then discard `mem_rdata`, load pc from `pending_pc`, go to FETCH.
- **Redirect** (has priority over stall and consume)
  - The target is `{redirect_pc[31:2],2'b00}`. If `redirect_pc[1:0]`≠0, pulse `misalign_err` the next cycle.
  - In HOLD: clear `instr_valid`, load pc, go to FETCH.
  - In FETCH with `mem_ack` in the same cycle: discard the data, load pc, stay in FETCH.
  - In FETCH without `mem_ack`: latch `pending_pc`, go to DRAIN.
  - In DRAIN: overwrite `pending_pc`; the last redirect wins.
  - If the DRAIN `mem_ack` and a new redirect occur in the same cycle, the new target is used.
- **Reset**
  - At any time, including while a request is outstanding: pc=`RESET_PC`, state=FETCH, `Instruction`=0, `instr_pc`=0, `instr_valid`=0, `misalign_err`=0, `mem_req`=0 for that cycle.
  - A late `mem_ack` arriving after reset that matches no outstanding request is ignored. The memory side must tolerate an abandoned request.

## Timing
- First `mem_req` is asserted the cycle after the first edge with `rst_n`=1.
- `mem_ack` in cycle N → `instr_valid`=1 from cycle N+1.
- Consume at edge in cycle M → `mem_req`=1 for the next pc in cycle M+1.
- With a zero-wait memory (ack in the same cycle as req), sustained throughput is 1 instruction per 2 cycles. No fetch overlap.
- Redirect in cycle R (HOLD) → `instr_valid`=0 and `mem_req`=1 at the target in R+1.
- `mem_addr` never changes while `mem_req`=1 and no ack has been received.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Shared package `fetch_pkg` contains:
  - state enum `fetch_state_t` {FETCH, HOLD, DRAIN};
  - `RESET_PC_DEFAULT`;
  - `PC_INC_DEFAULT`;
  - `WORD_ALIGN_MASK` (32'hFFFF_FFFC).
- One sub-module `fetch_pc_reg`: the PC register with increment, redirect load, alignment masking and `misalign_err` generation.
- The FSM and instruction register remain in the top module.

## Test plan
- Reset, zero-wait memory returning 32'h1111_1111 at 0 and 32'h2222_2222 at 4, `stall`=0 → `mem_addr` sequence 0, 4, 8. `Instruction` sequence 32'h1111_1111 then 32'h2222_2222, one instruction per 2 cycles.
- `stall`=1 for 5 cycles in HOLD with instruction 32'hDEAD_BEEF at pc 0x10 → `Instruction`, `instr_pc`=0x10 and `instr_valid` held; `mem_req`=0 throughout. Next fetch is at 0x14.
- Memory with 3-cycle latency; redirect to 0x100 one cycle after req at 0x20 → `mem_addr` holds 0x20 until ack, that data is never presented, next `mem_addr`=0x100.
- Two redirects (0x200 then 0x300) during DRAIN → only 0x300 is fetched.
- Redirect to 0x0000_0103 in HOLD → `misalign_err` pulses once, next `mem_addr`=0x100, held instruction dropped.
- pc=0xFFFF_FFFC consumed → next `mem_addr`=0x0000_0000. Apply `rst_n`=0 mid-fetch → all outputs zero next cycle, then fetch restarts at `RESET_PC`.
